// File: rtl/mux_arb.sv
// N-channel registered multiplexer/arbiter with valid/ready handshaking.
// Supports fixed-priority, round-robin and explicit-select arbitration, chosen per cycle by mode.
module mux_arb #(
    parameter int unsigned NCH  = 5,
    parameter int unsigned DW   = 16,
    parameter int unsigned SELW = 3
) (
    input  logic                mclk,
    input  logic                mreset,
    input  logic [1:0]          mode,
    input  logic [SELW-1:0]     sel,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*DW-1:0]   in_data,
    output logic [NCH-1:0]      in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [SELW-1:0]     out_ch,
    input  logic                out_ready
);

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_RR    = 2'd1,
        MODE_SEL   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;

    logic            load_c;
    logic            gnt_any_c;
    logic [SELW-1:0] gnt_idx_c;
    logic            xfer_c;

    // Grant selection; loops run from the far end so the preferred candidate is written last.
    always_comb begin
        int unsigned c;
        logic [SELW-1:0] idx;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        c         = 0;
        idx       = '0;
        case (mode)
            MODE_FIXED: begin
                for (int unsigned i = NCH; i > 0; i--) begin
                    idx = SELW'(i - 1);
                    if (in_valid[idx]) begin
                        gnt_any_c = 1'b1;
                        gnt_idx_c = idx;
                    end
                end
            end
            MODE_RR: begin
                for (int unsigned k = NCH; k > 0; k--) begin
                    c   = (32'(rr_ptr_q) + k - 1) % NCH;
                    idx = SELW'(c);
                    if (in_valid[idx]) begin
                        gnt_any_c = 1'b1;
                        gnt_idx_c = idx;
                    end
                end
            end
            MODE_SEL: begin
                if (32'(sel) < NCH) begin
                    if (in_valid[sel]) begin
                        gnt_any_c = 1'b1;
                        gnt_idx_c = sel;
                    end
                end
            end
            default: begin
                gnt_any_c = 1'b0;
            end
        endcase
    end

    assign load_c   = !out_valid_q || out_ready;
    assign xfer_c   = load_c && gnt_any_c && !mreset;
    assign in_ready = xfer_c ? (NCH'(1) << gnt_idx_c) : '0;

    // Output register and round-robin pointer update.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[32'(gnt_idx_c) * DW +: DW];
            out_ch_d    = gnt_idx_c;
            if (mode == MODE_RR) begin
                rr_ptr_d = (32'(gnt_idx_c) == NCH - 1) ? '0 : gnt_idx_c + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_ch_d    = '0;
        end
    end

    always_ff @(posedge mclk or posedge mreset) begin
        if (mreset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: directed scenarios plus randomized traffic,
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_mux_arb;

    localparam int unsigned NCH  = 5;
    localparam int unsigned DW   = 16;
    localparam int unsigned SELW = 3;

    logic                mclk = 1'b0;
    logic                mreset;
    logic [1:0]          mode;
    logic [SELW-1:0]     sel;
    logic [NCH-1:0]      in_valid;
    logic [NCH*DW-1:0]   in_data;
    logic [NCH-1:0]      in_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [SELW-1:0]     out_ch;
    logic                out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_rr;
    bit m_valid;
    int m_data;
    int m_ch;

    mux_arb #(.NCH(NCH), .DW(DW), .SELW(SELW)) dut (
        .mclk      (mclk),
        .mreset    (mreset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 mclk = ~mclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Channel the rules award this cycle, or -1 for none.
    function automatic int model_grant();
        if (m_valid && !out_ready) return -1;
        case (mode)
            2'd0: begin
                for (int i = 0; i < NCH; i++) if (in_valid[i]) return i;
            end
            2'd1: begin
                for (int k = 0; k < NCH; k++) begin
                    int c;
                    c = (m_rr + k) % NCH;
                    if (in_valid[c]) return c;
                end
            end
            2'd2: begin
                if (int'(sel) < NCH && in_valid[sel]) return int'(sel);
            end
            default: return -1;
        endcase
        return -1;
    endfunction

    function automatic void model_reset();
        m_rr    = 0;
        m_valid = 0;
        m_data  = 0;
        m_ch    = 0;
    endfunction

    // One clock: check in_ready mid-cycle, advance model at the edge, check outputs just after.
    task automatic step();
        int g;
        logic [NCH-1:0] exp_rdy;
        @(negedge mclk);
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0 && !mreset) exp_rdy[g] = 1'b1;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge mclk);
        if (mreset) begin
            model_reset();
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = int'(in_data[g*DW +: DW]);
            m_ch    = g;
            if (mode == 2'd1) m_rr = (g + 1) % NCH;
        end else if (out_ready) begin
            m_valid = 0;
            m_data  = 0;
            m_ch    = 0;
        end
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", 32'(out_data), 32'(m_data));
        check_eq("out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    task automatic set_data_seq(input int base);
        for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = DW'(base + i);
    endtask

    initial begin
        int exp_seq[6];
        int exp_pair[4];
        logic [DW-1:0] held;
        exp_seq  = '{0, 1, 2, 3, 4, 0};
        exp_pair = '{1, 3, 1, 3};

        mreset    = 1'b1;
        mode      = 2'd0;
        sel       = '0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        mreset = 1'b0;

        // Round-robin from a fresh pointer: full sweep with wrap.
        mode = 2'd1; out_ready = 1'b1; in_valid = '1; set_data_seq(16'h0A);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("rr_seq", 32'(out_ch), 32'(exp_seq[i]));
        end
        in_valid = 5'b01010;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rr_pair", 32'(out_ch), 32'(exp_pair[i]));
        end

        // Fixed priority: channel 0 always wins.
        mode = 2'd0; in_valid = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fixed_data", 32'(out_data), 32'h000A);
            check_eq("fixed_ch", 32'(out_ch), 32'd0);
        end

        // Explicit select, then an out-of-range select draining the output.
        mode = 2'd2; sel = 3'd3; in_valid = 5'b01000; in_data[3*DW +: DW] = 16'h1234;
        step();
        check_eq("sel_data", 32'(out_data), 32'h1234);
        check_eq("sel_ch", 32'(out_ch), 32'd3);
        sel = 3'd6; in_valid = '1;
        step();
        check_eq("sel_oob_valid", 32'(out_valid), 32'd0);
        step();

        // Back-pressure for four cycles, then a refill with no bubble.
        mode = 2'd0; in_valid = 5'b00001; set_data_seq(16'h0500);
        step();
        held = out_data;
        out_ready = 1'b0; in_valid = '1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_hold", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1; in_valid = 5'b00100;
        step();
        check_eq("refill_valid", 32'(out_valid), 32'd1);
        check_eq("refill_ch", 32'(out_ch), 32'd2);

        // Pointer persists across a detour through fixed priority.
        mode = 2'd1; in_valid = 5'b00100;
        step();
        mode = 2'd0; in_valid = '1;
        repeat (3) step();
        mode = 2'd1;
        step();
        check_eq("rr_resume", 32'(out_ch), 32'd3);

        // Reserved mode grants nothing.
        mode = 2'd3;
        repeat (3) step();
        check_eq("rsvd_drain", 32'(out_valid), 32'd0);

        // Asynchronous reset with a word held and in_ready active.
        mode = 2'd0; in_valid = '1; out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        #1;
        check_eq("pre_rst_ready", 32'(in_ready), 32'd1);
        mreset = 1'b1;
        #1;
        check_eq("async_valid", 32'(out_valid), 32'd0);
        check_eq("async_data", 32'(out_data), 32'd0);
        check_eq("async_ch", 32'(out_ch), 32'd0);
        check_eq("async_ready", 32'(in_ready), 32'd0);
        model_reset();
        step();
        mreset = 1'b0;
        mode = 2'd1; in_valid = '1;
        step();
        check_eq("post_rst_rr", 32'(out_ch), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            mode      = 2'($urandom_range(0, 3));
            sel       = SELW'($urandom);
            in_valid  = NCH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            mreset    = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = DW'($urandom);
            step();
            mreset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-channel, W-bit registered multiplexer/arbiter. It is the next generation of the cell-library mux cell: a configurable channel count and data width, valid/ready handshaking on every channel, and a run-time mode selecting fixed-priority, round-robin or explicit-select arbitration. The selected word lands in a single output register. It sits between multiple producers and one consumer anywhere a shared datapath is fed from several sources.

## Interface
- NCH, 5, number of input channels (2..16)
- DW, 16, data width per channel
- SELW, 3, select/channel-index width; must satisfy 2**SELW >= NCH
- mclk  input  1  clock, all state on rising edge
- mreset  input  1  asynchronous, active-high reset
- mode  input  2  0 fixed priority, 1 round-robin, 2 explicit select, 3 reserved
- sel  input  SELW  channel index used in mode 2
- in_valid  input  NCH  per-channel request, bit i = channel i
- in_data  input  NCH*DW  channel i occupies bits [i*DW +: DW]
- in_ready  output  NCH  per-channel accept, combinational
- out_valid  output  1  output register holds a word
- out_data  output  DW  registered selected word
- out_ch  output  SELW  index of channel that supplied out_data
- out_ready  input  1  consumer accept

## Operation
- load = !out_valid | out_ready. At most one grant bit is set per cycle. in_ready[i] = load & grant[i] & !mreset.
- A transfer on channel k happens when in_valid[k] & in_ready[k].
- Mode 0: grant goes to the lowest-index channel with in_valid set.
- Mode 1: grant goes to the first valid channel searching upward from rr_ptr, wrapping from NCH-1 to 0.
  - After a transfer on channel k, rr_ptr <= (k == NCH-1) ? 0 : k+1.
  - rr_ptr does not change in any other mode or on a cycle with no transfer.
- Mode 2: grant[sel] = in_valid[sel] when sel < NCH. When sel >= NCH, there is no grant.
- Mode 3: no grant. All in_ready stay 0 and the output drains normally.
- Mode and sel are sampled combinationally every cycle. A change takes effect in the same cycle. rr_ptr persists across mode changes.
- Output register, in priority order:
  - On a transfer on channel k: out_valid <= 1, out_data <= in_data[k], out_ch <= k.
  - Else if out_ready: out_valid <= 0, out_data <= 0, out_ch <= 0.
  - Else: hold all values.
- When out_valid = 0, out_data = 0 and out_ch = 0 at all times. This preserves the legacy "no selection yields 0" behaviour.
- Reset clears out_valid, out_data, out_ch and rr_ptr to 0 asynchronously. A word held in the output register is discarded. The upstream word is not consumed, because in_ready = 0 during reset.

## Timing
- Latency is 1 cycle: a word accepted at edge n is visible on out_data after edge n.
- Throughput is 1 word/cycle while out_ready = 1.
- Back-pressure: when out_valid = 1 and out_ready = 0, all in_ready are 0 and the output holds stably.
- Simultaneous drain and refill (out_valid = 1, out_ready = 1, transfer) gives a back-to-back word with out_valid staying 1.
- Combinational paths: in_valid/mode/sel/out_valid/out_ready -> in_ready. There is no combinational path from in_data to any output.
- Reset release: the first transfer can occur on the first rising edge after mreset deasserts.

## Test plan
- Reset: assert mreset mid-stream with out_valid = 1 -> out_valid, out_data, out_ch and in_ready are 0 immediately, without waiting for a clock edge. rr_ptr is 0 after release, so mode 1 with all valid grants channel 0 first.
- Mode 0 with all five channels valid, data 0x0A..0x0E, out_ready = 1 -> ch0 is granted every cycle; out_data = 0x000A, out_ch = 0 from the cycle after the first edge.
- Mode 1 with all five channels valid and out_ready = 1 -> out_ch sequence 0,1,2,3,4,0; wrap at 4 -> 0 confirmed. With only ch1 and ch3 valid -> 1,3,1,3.
- Mode 2: sel = 3 with ch3 valid, data 0x1234 -> out_data = 0x1234, out_ch = 3. sel = 6 -> no in_ready asserted and out_valid drops to 0 after the drain.
- Back-pressure: out_ready = 0 for 4 cycles after a capture -> out_data stable and in_ready = 0. Raising out_ready with ch2 valid -> refill in the same cycle with no bubble.
- Mode switch from 1 to 0 to 1 with rr_ptr = 3 -> mode 0 grants do not move rr_ptr; on returning to mode 1, the next grant comes from ch3 if valid.
